// File: rtl/cv32e40p_print_tx_buffer.sv
// Elastic byte FIFO between the subsystem print port and the UART transmitter.
// Drains one byte per UART start/busy handshake and re-issues a start the UART never acknowledged.
module cv32e40p_print_tx_buffer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BUSY_TIMEOUT = 32,
    parameter int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             print_valid_i,
    input  logic [31:0]      print_wdata_i,
    output logic             tx_start_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_busy_i,
    output logic [CNT_W-1:0] fifo_count_o,
    output logic             overflow_o,
    output logic [15:0]      drop_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [AW:0]        wptr_q, wptr_d;
    logic [AW:0]        rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [TW-1:0]      timeout_q, timeout_d;

    logic full, empty, push, pop, drop;
    logic unused_wdata;

    assign unused_wdata = ^print_wdata_i[31:8];

    // Extra pointer MSB distinguishes a full buffer from an empty one at equal addresses.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A full FIFO still accepts a write in the cycle the head is popped.
    assign push = print_valid_i && (!full || pop);
    assign drop = print_valid_i && !push;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        timeout_d = timeout_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rptr_q[AW-1:0]];
                    state_d   = START;
                end
            end
            START: begin
                timeout_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (timeout_q == TIMEOUT_LAST) begin
                    state_d = START;
                end else begin
                    timeout_d = timeout_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d     = push ? wptr_q + {{AW{1'b0}}, 1'b1} : wptr_q;
        rptr_d     = pop  ? rptr_q + {{AW{1'b0}}, 1'b1} : rptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            tx_data_q  <= 8'h00;
            timeout_q  <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= print_wdata_i[7:0];
    end

    assign tx_start_o   = (state_q == START);
    assign tx_data_o    = tx_data_q;
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_cv32e40p_print_tx_buffer.sv
// Randomized bench for the print TX buffer: a transaction-level FIFO model feeds a scoreboard
// that a UART-side monitor checks against every start pulse, byte hold and status output.
module tb_cv32e40p_print_tx_buffer;

    localparam int DEPTH = 16;
    localparam int BT    = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             print_valid_i;
    logic [31:0]      print_wdata_i;
    logic             tx_start_o;
    logic [7:0]       tx_data_o;
    logic             tx_busy_i;
    logic [CNT_W-1:0] fifo_count_o;
    logic             overflow_o;
    logic [15:0]      drop_count_o;

    logic uart_busy  = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy_i = uart_busy | force_busy;

    cv32e40p_print_tx_buffer #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .print_valid_i (print_valid_i),
        .print_wdata_i (print_wdata_i),
        .tx_start_o    (tx_start_o),
        .tx_data_o     (tx_data_o),
        .tx_busy_i     (tx_busy_i),
        .fifo_count_o  (fifo_count_o),
        .overflow_o    (overflow_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // UART timing knobs (written by stimulus only) and ignore-start handshake counters.
    int dly_lo = 1, dly_hi = 1, len_lo = 10, len_hi = 10;
    int ign_req = 0, ign_done = 0;

    // Latency probe: stimulus posts a write cycle, monitor measures the next fresh start.
    int lat_w = 0, lat_req = 0, lat_done = 0;

    // Reference model state, owned by the monitor.
    logic [7:0] exp_q[$];
    int         occ = 0;
    int         drops = 0;
    logic       ovf = 1'b0;
    logic       in_flight = 1'b0, busy_seen = 1'b0, prev_start = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00, cur_b = 8'h00, exp_b;
    int         fall_cyc = -1000, last_start = 0, rep_cnt = 0;

    // UART model: answers each start with busy after a delay, except starts it was told to ignore.
    initial begin
        int d, len;
        forever begin
            @(negedge clk_i);
            if (rst_ni && tx_start_o) begin
                if (ign_req != ign_done) begin
                    ign_done++;
                end else begin
                    d   = $urandom_range(dly_hi, dly_lo);
                    len = $urandom_range(len_hi, len_lo);
                    repeat (d) @(posedge clk_i);
                    #1 uart_busy = 1'b1;
                    repeat (len) @(posedge clk_i);
                    #1 uart_busy = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    initial begin
        logic new_start, acc;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                check("rst_tx_start", tx_start_o, 0);
                check("rst_tx_data", tx_data_o, 0);
                check("rst_fifo_count", fifo_count_o, 0);
                check("rst_overflow", overflow_o, 0);
                check("rst_drop_count", drop_count_o, 0);
                exp_q.delete();
                occ = 0; drops = 0; ovf = 1'b0;
                in_flight = 1'b0; busy_seen = 1'b0; prev_start = 1'b0; prev_valid = 1'b0;
                fall_cyc = -1000;
            end else begin
                new_start = tx_start_o && !in_flight;
                if (tx_start_o && prev_start) check("start_one_cycle", 1, 0);
                if (new_start) begin
                    if (fall_cyc >= 0) check("gap_after_busy_ok", (cyc - fall_cyc >= 2), 1);
                    if (exp_q.size() == 0) begin
                        check("start_without_data", 1, 0);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("tx_order", tx_data_o, exp_b);
                    end
                    if (lat_req != lat_done) begin
                        check("start_latency", cyc - lat_w, 2);
                        lat_done = lat_req;
                    end
                    cur_b = tx_data_o; in_flight = 1'b1; busy_seen = 1'b0; last_start = cyc;
                end else if (tx_start_o) begin
                    check("repulse_before_busy", busy_seen, 0);
                    check("repulse_data", tx_data_o, cur_b);
                    check("repulse_gap_ok", (cyc - last_start == BT) || (cyc - last_start == BT + 1), 1);
                    rep_cnt++;
                    last_start = cyc;
                end else if (in_flight) begin
                    check("tx_data_hold", tx_data_o, cur_b);
                    if (tx_busy_i) begin
                        busy_seen = 1'b1;
                    end else if (busy_seen) begin
                        in_flight = 1'b0;
                        fall_cyc  = cyc;
                    end
                end

                // Settle last cycle's write: a full FIFO only takes it if the head left that cycle.
                acc = prev_valid && ((occ < DEPTH) || new_start);
                if (new_start && occ > 0) occ--;
                if (acc) begin
                    exp_q.push_back(prev_data);
                    occ++;
                end else if (prev_valid) begin
                    ovf = 1'b1;
                    if (drops < 16'hFFFF) drops++;
                end
                check("fifo_count", fifo_count_o, occ);
                check("drop_count", drop_count_o, drops);
                check("overflow", overflow_o, ovf);

                prev_valid = print_valid_i;
                prev_data  = print_wdata_i[7:0];
                prev_start = tx_start_o;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk_i);
        #1;
        print_valid_i      = 1'b1;
        print_wdata_i      = $urandom;
        print_wdata_i[7:0] = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1 print_valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && !in_flight && fifo_count_o == 0) && k < limit) begin
            @(posedge clk_i);
            #1 k++;
        end
        check(name, (k < limit), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string s;
        int drops_before, reps_before;
        s = "Hello, world!:-)";
        rst_ni = 1'b0;
        print_valid_i = 1'b0;
        print_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single byte written in cycle 10, UART busy one cycle after start for 100 cycles.
        dly_lo = 1; dly_hi = 1; len_lo = 100; len_hi = 100;
        while (cyc < 9) @(posedge clk_i);
        push(8'h41);
        lat_w = cyc; lat_req++;
        idle(1);
        wait_drain("single_drain", 300);

        // Burst of 16 into a slow UART; one byte leaves as the burst arrives.
        dly_lo = 1; dly_hi = 2; len_lo = 30; len_hi = 40;
        for (int i = 0; i < 16; i++) push(s[i]);
        idle(1);
        check("burst_peak_ok", (fifo_count_o == 15) || (fifo_count_o == 16), 1);
        wait_drain("burst_drain", 1500);

        // 20 writes against a held busy: the first byte leaves, 16 are stored, the rest drop.
        dly_lo = 1; dly_hi = 1; len_lo = 20; len_hi = 30;
        force_busy = 1'b1;
        for (int i = 0; i < 20; i++) push(8'(8'h60 + i));
        idle(1);
        check("ovf_drop_count_ok", (drop_count_o == 3) || (drop_count_o == 4), 1);
        check("ovf_set", overflow_o, 1);
        idle(50);
        check("ovf_sticky", overflow_o, 1);
        check("ovf_full", fifo_count_o, DEPTH);

        // Release busy while writing continuously: only the write coinciding with the pop lands.
        drops_before = drop_count_o;
        @(posedge clk_i);
        #1;
        force_busy    = 1'b0;
        print_valid_i = 1'b1;
        print_wdata_i = 32'h0000_00A0;
        for (int i = 1; i < 6; i++) push(8'(8'hA0 + i));
        idle(1);
        check("pushpop_drops", drop_count_o, drops_before + 5);
        check("pushpop_count", fifo_count_o, DEPTH);
        wait_drain("pushpop_drain", 2000);

        // UART ignores the first start: the same byte must be re-pulsed.
        dly_lo = 1; dly_hi = 2; len_lo = 5; len_hi = 10;
        reps_before = rep_cnt;
        ign_req++;
        push(8'($urandom));
        idle(1);
        wait_drain("timeout_drain", 400);
        check("timeout_repulses", rep_cnt, reps_before + 1);

        // Random traffic with random UART timing and occasional unanswered starts.
        dly_lo = 1; dly_hi = 3; len_lo = 2; len_hi = 12;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i);
            #1;
            print_valid_i = ($urandom_range(9, 0) < 3);
            print_wdata_i = $urandom;
            if (ign_req == ign_done && $urandom_range(59, 0) == 0) ign_req++;
        end
        idle(1);
        wait_drain("random_drain", 3000);

        // Asynchronous reset with bytes queued and the transmitter waiting for busy to fall.
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
        idle(10);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        force_busy = 1'b0;
        idle(40);
        check("post_reset_empty", fifo_count_o, 0);
        push(8'h5A);
        idle(1);
        wait_drain("post_reset_drain", 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_print_tx_buffer.md
Name: cv32e40p_print_tx_buffer

Overview:
- Elastic byte buffer between the subsystem print port (print_valid/print_wdata) and the UART transmitter.
- Absorbs back-to-back print writes from the core, which arrive far faster than the UART baud rate.
- Drains bytes one at a time using the UART start/busy handshake.
- Reports fill level, and counts bytes dropped on overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- BUSY_TIMEOUT, 32, cycles to wait for tx_busy_i to rise after a start pulse before the start is re-issued; at least 1.
- CNT_W, $clog2(DEPTH)+1, width of fifo_count_o.

Ports:
- clk_i  in  1  clock, same domain as the subsystem and UART.
- rst_ni  in  1  asynchronous active-low reset.
- print_valid_i  in  1  one-cycle write strobe from the subsystem print port.
- print_wdata_i  in  32  print data; only bits [7:0] are used.
- tx_start_o  out  1  one-cycle start pulse to the UART transmitter.
- tx_data_o  out  8  byte to transmit; held stable from the start pulse until the byte completes.
- tx_busy_i  in  1  UART transmitter busy.
- fifo_count_o  out  CNT_W  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky; set on the first dropped byte.
- drop_count_o  out  16  dropped-byte count, saturating at 16'hFFFF.

Behaviour:
- Reset, asynchronous with rst_ni=0:
  - tx_start_o=0, tx_data_o=8'h00, fifo_count_o=0, overflow_o=0, drop_count_o=0, FSM=IDLE.
  - Read/write pointers and the timeout counter are cleared.
  - Reset mid-transmission discards all buffered and in-flight bytes; no start pulse is issued until a new write arrives.
- FIFO:
  - Circular buffer of DEPTH bytes with pointers one bit wider than the address; full/empty derived from the pointers.
  - Push when print_valid_i=1 and not full.
  - Push while full: the byte is dropped, overflow_o is set, and drop_count_o increments (no wrap past FFFF).
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
  - No bypass: a byte written into an empty FIFO is popped at the earliest on the next cycle.
  - Pointers wrap modulo DEPTH. fifo_count_o is registered and updated on the same edge as the push/pop.
- FSM, all transitions registered:
  - IDLE: if the FIFO is non-empty, pop the head, load it into tx_data_o, go to START.
  - START: tx_start_o=1 for exactly this cycle. Clear the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY:
    - If tx_busy_i=1, go to WAIT_DONE.
    - Otherwise increment the timeout counter; when it reaches BUSY_TIMEOUT-1, go to START and re-pulse with the same tx_data_o. The byte is not lost.
  - WAIT_DONE: when tx_busy_i=0, go to IDLE.
  - tx_start_o is 0 in every state except START.
- Latency:
  - print_valid_i in cycle c with the FIFO empty and FSM in IDLE gives tx_start_o=1 in cycle c+2.
  - Between consecutive bytes: minimum 2 cycles from tx_busy_i falling to the next tx_start_o.
- Ordering: bytes are transmitted strictly in write order; never duplicated except by the timeout re-pulse.
- tx_busy_i already high in IDLE is ignored; it is only sampled in WAIT_BUSY and WAIT_DONE.

Test Plan:
- Single byte:
  - Stimulus: print_wdata_i=32'h0000_0041 pulsed in cycle 10; UART model raises busy 1 cycle after start and holds it 100 cycles.
  - Required: tx_start_o high only in cycle 12, tx_data_o=8'h41 stable until busy falls, fifo_count_o returns to 0, FSM back in IDLE.
- Burst:
  - Stimulus: 16 consecutive writes of 'H','e','l','l','o',... with DEPTH=16 and a slow UART.
  - Required: all 16 bytes transmitted in order, overflow_o=0, fifo_count_o peaks at 15 or 16.
- Overflow:
  - Stimulus: 20 back-to-back writes while UART busy is held high.
  - Required: drop_count_o=3 or 4 (matching the pop timing), overflow_o=1 and sticky; the surviving bytes are the first ones, in order.
- Full with simultaneous push/pop:
  - Stimulus: push exactly as the FSM pops from a full FIFO.
  - Required: push accepted, fifo_count_o stays at DEPTH, drop_count_o unchanged.
- Busy timeout:
  - Stimulus: UART never raises busy for the first start.
  - Required: tx_start_o re-pulses after BUSY_TIMEOUT cycles with the same tx_data_o; after busy responds, transmission completes normally.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 asynchronously with 5 bytes queued and FSM in WAIT_DONE.
  - Required: all outputs go to reset values immediately; after release, no tx_start_o until a new print_valid_i.
